index_batch_packer: RTL and testbench

//  Producer-side counterpart of the first-set-bit batch consumer: collects a stream of bit

---
 rtl/index_batch_packer.sv | 151 +++++++++++++++
 tb/tb_index_batch_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/index_batch_packer.sv
// Packs a stream of bit indices into a SIZE-bit batch vector and hands
// finished batches out through a valid/ready slot. Optional: PACKER_DUP_ERR_EN.
module index_batch_packer #(
    parameter int SIZE     = 64,
    parameter int log_SIZE = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                idx_valid,
    input  logic [log_SIZE-1:0] idx_in,
    output logic                idx_ready,
    input  logic                flush,
    output logic [SIZE-1:0]     batch_out,
    output logic [log_SIZE:0]   batch_count,
    output logic                batch_valid,
    input  logic                batch_ready
`ifdef PACKER_DUP_ERR_EN
    ,
    output logic                dup_err
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_CLOSE = 2'd2
    } state_t;

    localparam logic [log_SIZE:0] FULL_CNT = (log_SIZE + 1)'(SIZE);

    state_t              state_q, state_d;
    logic [SIZE-1:0]     acc_q, acc_d;
    logic [log_SIZE:0]   acc_cnt_q, acc_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic [SIZE-1:0]     batch_out_q, batch_out_d;
    logic [log_SIZE:0]   batch_count_q, batch_count_d;
    logic                batch_valid_q, batch_valid_d;
    logic                dup_err_q, dup_err_d;

    logic                transfer;
    logic                accept;
    logic                in_range;
    logic                set_en;
    logic [SIZE-1:0]     acc_base;
    logic [log_SIZE:0]   cnt_base;

    // Handshake: a closing batch moves to the slot when the slot is free or
    // being popped; a full accumulator only takes an index on that cycle.
    always_comb begin
        transfer  = (state_q == S_CLOSE) && (!batch_valid_q || batch_ready);
        idx_ready = (acc_cnt_q != FULL_CNT) || transfer;
        accept    = idx_valid && idx_ready;
        in_range  = ({1'b0, idx_in} < FULL_CNT);
        set_en    = accept && in_range;
    end

    // Accumulator: an index taken on the transfer cycle starts a fresh batch.
    always_comb begin
        acc_base  = transfer ? '0 : acc_q;
        cnt_base  = transfer ? '0 : acc_cnt_q;
        acc_d     = acc_base;
        acc_cnt_d = cnt_base;
        dup_err_d = 1'b0;
        if (set_en) begin
            if (acc_base[idx_in]) begin
                dup_err_d = 1'b1;
            end else begin
                acc_d[idx_in] = 1'b1;
                acc_cnt_d     = cnt_base + 1'b1;
            end
        end
    end

    // Early-close request: only meaningful while the next acc is nonempty.
    always_comb begin
        flush_pend_d = 1'b0;
        if (transfer) begin
            flush_pend_d = flush && (acc_cnt_d != '0);
        end else begin
            flush_pend_d = (flush_pend_q || flush) && (acc_cnt_d != '0);
        end
    end

    // Next state follows the post-edge fill level and close request.
    always_comb begin
        state_d = state_q;
        if (acc_cnt_d == '0) begin
            state_d = S_EMPTY;
        end else if ((acc_cnt_d == FULL_CNT) || flush_pend_d) begin
            state_d = S_CLOSE;
        end else begin
            state_d = S_FILL;
        end
    end

    // Output slot: load on transfer, drop valid on a pop with no new batch.
    always_comb begin
        batch_out_d   = batch_out_q;
        batch_count_d = batch_count_q;
        batch_valid_d = batch_valid_q;
        if (transfer) begin
            batch_out_d   = acc_q;
            batch_count_d = acc_cnt_q;
            batch_valid_d = 1'b1;
        end else if (batch_valid_q && batch_ready) begin
            batch_valid_d = 1'b0;
        end
    end

    // State register for the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, slot and duplicate pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            flush_pend_q  <= 1'b0;
            batch_out_q   <= '0;
            batch_count_q <= '0;
            batch_valid_q <= 1'b0;
            dup_err_q     <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            flush_pend_q  <= flush_pend_d;
            batch_out_q   <= batch_out_d;
            batch_count_q <= batch_count_d;
            batch_valid_q <= batch_valid_d;
            dup_err_q     <= dup_err_d;
        end
    end

    assign batch_out   = batch_out_q;
    assign batch_count = batch_count_q;
    assign batch_valid = batch_valid_q;

`ifdef PACKER_DUP_ERR_EN
    assign dup_err = dup_err_q;
`else
    logic unused_dup;
    assign unused_dup = dup_err_q;
`endif

endmodule

// File: tb/tb_index_batch_packer.sv
// Directed bench for index_batch_packer: table of short batches plus
// hand-written sequences for fill, backpressure, flush and reset corners.
module tb_index_batch_packer;

    logic        clk;
    logic        rst_n;
    logic        idx_valid;
    logic [5:0]  idx_in;
    logic        idx_ready;
    logic        flush;
    logic [63:0] batch_out;
    logic [6:0]  batch_count;
    logic        batch_valid;
    logic        batch_ready;
`ifdef PACKER_DUP_ERR_EN
    logic        dup_err;
    int          dup_seen = 0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    index_batch_packer #(.SIZE(64), .log_SIZE(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_valid   (idx_valid),
        .idx_in      (idx_in),
        .idx_ready   (idx_ready),
        .flush       (flush),
        .batch_out   (batch_out),
        .batch_count (batch_count),
        .batch_valid (batch_valid),
        .batch_ready (batch_ready)
`ifdef PACKER_DUP_ERR_EN
        ,
        .dup_err     (dup_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PACKER_DUP_ERR_EN
    always @(negedge clk) if (dup_err) dup_seen++;
`endif

    typedef struct {
        int               n;
        logic [3:0][5:0]  idx;
        logic [63:0]      exp_out;
        logic [6:0]       exp_cnt;
        int               exp_dup;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (batch_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (batch_valid) ok = 1'b1;
    endtask

    task automatic run_vec(input int v);
        bit ok;
`ifdef PACKER_DUP_ERR_EN
        int d0;
        d0 = dup_seen;
`endif
        batch_ready = 1'b0;
        for (int i = 0; i < vecs[v].n; i++) begin
            idx_valid = 1'b1;
            idx_in    = vecs[v].idx[i];
            tick();
        end
        idx_valid = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        wait_valid(10, ok);
        chk($sformatf("vec%0d_valid", v), 64'(ok), 64'd1);
        chk($sformatf("vec%0d_out", v), batch_out, vecs[v].exp_out);
        chk($sformatf("vec%0d_cnt", v), 64'(batch_count),
            64'(vecs[v].exp_cnt));
`ifdef PACKER_DUP_ERR_EN
        chk($sformatf("vec%0d_dup", v), 64'(dup_seen - d0),
            64'(vecs[v].exp_dup));
`endif
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        chk($sformatf("vec%0d_pop", v), 64'(batch_valid), 64'd0);
    endtask

    initial begin
        bit ok;
        bit rdy_low;
        bit seen;

        vecs[0] = '{3, {6'd0, 6'd63, 6'd5, 6'd0},
                    64'h8000_0000_0000_0021, 7'd3, 0};
        vecs[1] = '{3, {6'd0, 6'd7, 6'd7, 6'd7},
                    64'h0000_0000_0000_0080, 7'd1, 2};
        vecs[2] = '{4, {6'd4, 6'd3, 6'd2, 6'd1},
                    64'h0000_0000_0000_001E, 7'd4, 0};
        vecs[3] = '{4, {6'd1, 6'd62, 6'd0, 6'd62},
                    64'h4000_0000_0000_0003, 7'd3, 1};
        vecs[4] = '{1, {6'd0, 6'd0, 6'd0, 6'd32},
                    64'h0000_0001_0000_0000, 7'd1, 0};

        rst_n       = 1'b0;
        idx_valid   = 1'b0;
        idx_in      = '0;
        flush       = 1'b0;
        batch_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(batch_valid), 64'd0);
        chk("rst_out", batch_out, 64'd0);
        chk("rst_cnt", 64'(batch_count), 64'd0);
        chk("rst_rdy", 64'(idx_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) run_vec(v);

        // Full batch of 0..63 with downstream always ready.
        batch_ready = 1'b1;
        rdy_low     = 1'b0;
        for (int i = 0; i < 64; i++) begin
            idx_valid = 1'b1;
            idx_in    = 6'(i);
            #0;
            if (!idx_ready) rdy_low = 1'b1;
            tick();
        end
        idx_valid = 1'b0;
        wait_valid(10, ok);
        chk("full_valid", 64'(ok), 64'd1);
        chk("full_out", batch_out, {64{1'b1}});
        chk("full_cnt", 64'(batch_count), 64'd64);
        chk("full_rdy_never_low", 64'(rdy_low), 64'd0);
        tick();
        chk("full_popped", 64'(batch_valid), 64'd0);
        batch_ready = 1'b0;

        // Two full batches with the slot blocked: second one stalls.
        rdy_low = 1'b0;
        for (int i = 0; i < 128; i++) begin
            idx_valid = 1'b1;
            idx_in    = 6'(i % 64);
            #0;
            if (!idx_ready) rdy_low = 1'b1;
            tick();
        end
        idx_valid = 1'b0;
        chk("bp_all_taken", 64'(rdy_low), 64'd0);
        tick();
        tick();
        chk("bp_stall_rdy", 64'(idx_ready), 64'd0);
        chk("bp_slot_valid", 64'(batch_valid), 64'd1);
        chk("bp_slot_cnt", 64'(batch_count), 64'd64);
        batch_ready = 1'b1;
        #0;
        chk("bp_rdy_on_pop", 64'(idx_ready), 64'd1);
        tick();
        batch_ready = 1'b0;
        chk("bp_no_bubble", 64'(batch_valid), 64'd1);
        chk("bp_second_out", batch_out, {64{1'b1}});
        chk("bp_second_cnt", 64'(batch_count), 64'd64);
        chk("bp_acc_free", 64'(idx_ready), 64'd1);
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        chk("bp_drained", 64'(batch_valid), 64'd0);

        // Flush with empty accumulator is dropped.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (batch_valid) seen = 1'b1;
            tick();
        end
        chk("empty_flush", 64'(seen), 64'd0);

        // Flush together with an index: minimum two-edge latency.
        flush     = 1'b1;
        idx_valid = 1'b1;
        idx_in    = 6'd9;
        tick();
        flush     = 1'b0;
        idx_valid = 1'b0;
        chk("fl9_edge1", 64'(batch_valid), 64'd0);
        tick();
        chk("fl9_edge2", 64'(batch_valid), 64'd1);
        chk("fl9_out", batch_out, 64'h200);
        chk("fl9_cnt", 64'(batch_count), 64'd1);

        // Reset while the slot is full and a new batch is filling.
        idx_valid = 1'b1;
        idx_in    = 6'd4;
        tick();
        idx_in = 6'd5;
        tick();
        idx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(batch_valid), 64'd0);
        chk("arst_out", batch_out, 64'd0);
        chk("arst_cnt", 64'(batch_count), 64'd0);
        chk("arst_rdy", 64'(idx_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (batch_valid) seen = 1'b1;
            tick();
        end
        chk("arst_acc_gone", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
